// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller uses the master modport; the datapath or a bench uses slave.
interface mc_control_if;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic [1:0]  alu_op;
  logic [7:0]  alu_func;
  logic        pc_en;
  logic [3:0]  state_o;
  logic        illegal;

  modport master (
    input  instr, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, pc_write, pc_write_cond, alu_src_b, pc_source, alu_op,
           alu_func, pc_en, state_o, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, pc_write, pc_write_cond, alu_src_b, pc_source, alu_op,
           alu_func, pc_en, state_o, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Moore control FSM for a multicycle 16-bit CPU: sequences fetch, decode,
// memory, execute and write-back steps and decodes datapath strobes per state.
module mc_control (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] opcode;

  assign opcode      = bus.instr[15:12];
  assign bus.state_o = state_reg;
  assign bus.pc_en   = bus.pc_write | (bus.pc_write_cond & bus.zero);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next        = FETCH;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.alu_func      = 8'h00;
    bus.illegal       = 1'b0;

    case (state_reg)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        state_next    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (opcode)
          4'b0000:          state_next = EXEC_R;
          4'b0001, 4'b0010: state_next = MEM_ADDR;
          4'b0011, 4'b0100: state_next = EXEC_I;
          4'b0101:          state_next = BRANCH;
          4'b0110:          state_next = JUMP;
          default: begin
            state_next  = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        // Anything other than a load or store cannot reach here; recover to FETCH.
        if (opcode == 4'b0001)      state_next = MEM_RD;
        else if (opcode == 4'b0010) state_next = MEM_WR;
        else                        state_next = FETCH;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_next   = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        state_next    = bus.mem_ready ? FETCH : MEM_WR;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b11;
        bus.alu_func  = bus.instr[7:0];
        state_next    = WB_R;
      end
      WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (opcode == 4'b0100) ? 2'b10 : 2'b00;
        state_next    = WB_I;
      end
      WB_I: bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: state_next = FETCH;
    endcase

    // Reset silences every strobe so an in-flight access is abandoned cleanly.
    if (rst) begin
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.pc_source     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.alu_func      = 8'h00;
      bus.illegal       = 1'b0;
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port instr  input  16  current instruction register contents; opcode = instr[15:12], func = instr[7:0].
REQ-004 SHALL have port zero  input  1  ALU zero flag.
REQ-005 SHALL have port mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-006 SHALL have outputs mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_write, pc_write_cond  output  1 each  datapath strobes and selects.
REQ-007 SHALL have outputs alu_src_b[1:0] (00 reg B, 01 const 1, 10 sext imm, 11 sext offset) and pc_source[1:0] (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have output alu_op[1:0]: 00 add, 01 subtract, 10 OR, 11 use alu_func; alu_func[7:0] drives the ALU func port.
REQ-009 SHALL have output pc_en  1  = pc_write OR (pc_write_cond AND zero).
REQ-010 SHALL have outputs state_o[3:0] (debug state encoding) and illegal (1-cycle pulse).

Function
REQ-011 SHALL be a Moore FSM; all outputs decode from the registered state, plus instr, zero and mem_ready where stated; any output not listed for a state is 0.
REQ-012 States and encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, WB_R 7, EXEC_I 8, WB_I 9, BRANCH 10, JUMP 11; codes 12-15 SHALL go to FETCH.
REQ-013 FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-014 DECODE: alu_src_b=11, alu_op=00; next state by opcode: 0000 EXEC_R, 0001/0010 MEM_ADDR, 0011/0100 EXEC_I, 0101 BRANCH, 0110 JUMP, others FETCH with illegal=1.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; opcode 0001 goes to MEM_RD, 0010 goes to MEM_WR.
REQ-016 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, then FETCH.
REQ-017 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-018 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=11, alu_func=instr[7:0], then WB_R; alu_func SHALL be 8'h00 in every other state.
REQ-019 WB_R: reg_write=1, reg_dst=1, then FETCH.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 for opcode 0011 and 10 for 0100, then WB_I. WB_I: reg_write=1, reg_dst=0, then FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10, then FETCH.
REQ-023 Latency with mem_ready held at 1 SHALL be: R-type 4, LW 5, SW 4, ADDI/ORI 4, BEQ 3, JMP 3, illegal 2 cycles.
REQ-024 mem_write and reg_write SHALL never both be 1; a mem_ready pulse outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-025 While rst=1 at a rising edge, the next state SHALL be FETCH regardless of current state or mem_ready.
REQ-026 While rst=1, all 1-bit outputs and pc_en, illegal SHALL be forced to 0, and all multi-bit outputs other than state_o to zero.
REQ-027 After rst deasserts, the first non-reset cycle SHALL be FETCH (state_o=0).
REQ-028 rst asserted during MEM_RD or MEM_WR SHALL abort the access; no write strobe is issued after the reset edge.

Verification
REQ-029 R-type: instr=16'h0008, mem_ready=1 -> states 0,1,6,7,0; in EXEC_R alu_op=11 and alu_func=8'h08; reg_write=1 only in WB_R.
REQ-030 LW with wait: instr=16'h1005, mem_ready=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read=i_or_d=1 throughout, then MEM_WB with mem_to_reg=1.
REQ-031 BEQ: instr=16'h5003 with zero=1 -> pc_en=1 in BRANCH, alu_op=01; repeat with zero=0 -> pc_en=0.
REQ-032 FETCH stall: mem_ready=0 for 5 cycles -> state_o=0, ir_write=pc_write=0, mem_read=1; on mem_ready=1 -> ir_write=pc_en=1, then DECODE.
REQ-033 Illegal: instr=16'hF000 -> DECODE with illegal=1 for exactly one cycle, then FETCH.
REQ-034 Reset mid-op: rst=1 in MEM_WR with mem_ready=0 -> all outputs 0 during reset; after release state_o=0 and mem_write never asserts.
